// File: rtl/alu_accumulator.sv
// Accumulator ALU: single-cycle ops on A and Result[WIDTH-1:0].
// ALU_ACC_MUL_EN adds the multi-cycle shift-add MUL (Op=6).
module alu_accumulator #(
    parameter int WIDTH = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [2:0]         Op,
    input  logic [WIDTH-1:0]   A,
    output logic [2*WIDTH-1:0] Result,
    output logic               Busy,
    output logic               Done
);

    localparam int RW = 2 * WIDTH;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_LOGIC  = 3'd2,
        OP_ANY    = 3'd3,
        OP_CONCAT = 3'd4,
        OP_HOLD   = 3'd5,
        OP_MUL    = 3'd6,
        OP_CLEAR  = 3'd7
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] b;
    logic [RW-1:0]    alu_res;
    logic [RW-1:0]    result_q, result_d;
    logic             done_q, done_d;

    assign op = op_e'(Op);
    assign b  = result_q[WIDTH-1:0];

    // Single-cycle datapath; B is always the low half of the accumulator.
    always_comb begin
        alu_res = result_q;
        case (op)
            OP_ADD:    alu_res = RW'({1'b0, A} + {1'b0, b});
            OP_SUB:    alu_res = RW'(A) - RW'(b);
            OP_LOGIC:  alu_res = {~(A ^ b), ~(A & b)};
            OP_ANY:    alu_res = RW'({WIDTH{|(A | b)}});
            OP_CONCAT: alu_res = {A, b};
            OP_HOLD:   alu_res = result_q;
            OP_MUL:    alu_res = result_q;
            OP_CLEAR:  alu_res = '0;
            default:   alu_res = result_q;
        endcase
    end

`ifdef ALU_ACC_MUL_EN
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE,
        S_MULT
    } state_e;

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic [RW-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   psum;
    logic [RW-1:0]    pstep;

    // One shift-add step: upper half accumulates, lower half holds the
    // remaining multiplier bits and shifts right each cycle.
    assign psum  = prod_q[0] ? ({1'b0, prod_q[RW-1:WIDTH]} + {1'b0, mcand_q})
                             : {1'b0, prod_q[RW-1:WIDTH]};
    assign pstep = {psum, prod_q[WIDTH-1:1]};

    // Next-state logic: accept in IDLE, iterate in MULT, load product at the end.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (op == OP_MUL) begin
                        state_d = S_MULT;
                        busy_d  = 1'b1;
                        prod_d  = {{WIDTH{1'b0}}, b};
                        mcand_d = A;
                        cnt_d   = '0;
                    end else begin
                        result_d = alu_res;
                        done_d   = 1'b1;
                    end
                end
            end
            S_MULT: begin
                prod_d = pstep;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = pstep;
                    cnt_d    = '0;
                end
            end
        endcase
    end

    // Registered state and outputs; Reset aborts any multiply in flight.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign Busy = busy_q;
`else
    // Without the multiplier every op, including Op=6, completes in one cycle.
    always_comb begin
        result_d = result_q;
        done_d   = 1'b0;
        if (Start) begin
            result_d = alu_res;
            done_d   = 1'b1;
        end
    end

    // Accumulator and completion pulse.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign Busy = 1'b0;
`endif

    assign Result = result_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_alu_accumulator.sv
// Directed bench for alu_accumulator (WIDTH=4 and WIDTH=8 instances).
// Expected results go through a scoreboard queue, popped on Done.
module tb_alu_accumulator;

    logic        clk;
    logic        rst;
    logic        st4, st8;
    logic [2:0]  op4, op8;
    logic [3:0]  a4;
    logic [7:0]  a8;
    logic [7:0]  res4;
    logic [15:0] res8;
    logic        busy4, busy8, done4, done8;

    int checks;
    int errors;
    logic [15:0] exp_q[$];

    alu_accumulator #(.WIDTH(4)) u4 (
        .Clock(clk), .Reset(rst), .Start(st4), .Op(op4), .A(a4),
        .Result(res4), .Busy(busy4), .Done(done4)
    );

    alu_accumulator #(.WIDTH(8)) u8 (
        .Clock(clk), .Reset(rst), .Start(st8), .Op(op8), .A(a8),
        .Result(res8), .Busy(busy8), .Done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait (bounded) for Done, compare against the scoreboard.
    // While waiting, Busy must be high and Result must hold its old value.
    // poke drives a Start Op=7 during the first busy cycle.
    task automatic run(input bit w8, input logic [2:0] op,
                       input logic [7:0] a, input logic [15:0] exp,
                       input int lat, input bit poke, input string tag);
        logic [15:0] prev;
        int n;
        @(negedge clk);
        prev = w8 ? res8 : 16'(res4);
        if (w8) begin
            st8 = 1'b1; op8 = op; a8 = a;
        end else begin
            st4 = 1'b1; op4 = op; a4 = a[3:0];
        end
        exp_q.push_back(exp);
        @(posedge clk); #1;
        st4 = 1'b0;
        st8 = 1'b0;
        n = 0;
        while (!(w8 ? done8 : done4) && n < 40) begin
            chk({tag, " busy"}, 16'(w8 ? busy8 : busy4), 16'd1);
            chk({tag, " hold"}, w8 ? res8 : 16'(res4), prev);
            if (poke && n == 0) begin
                if (w8) begin
                    st8 = 1'b1; op8 = 3'd7;
                end else begin
                    st4 = 1'b1; op4 = 3'd7;
                end
            end
            @(posedge clk); #1;
            st4 = 1'b0;
            st8 = 1'b0;
            n++;
        end
        chk({tag, " done"}, 16'(w8 ? done8 : done4), 16'd1);
        chk({tag, " latency"}, 16'(n), 16'(lat));
        chk({tag, " busy_end"}, 16'(w8 ? busy8 : busy4), 16'd0);
        chk({tag, " result"}, w8 ? res8 : 16'(res4), exp_q.pop_front());
        @(posedge clk); #1;
        chk({tag, " done_low"}, 16'(w8 ? done8 : done4), 16'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        st4 = 1'b0; op4 = '0; a4 = '0;
        st8 = 1'b0; op8 = '0; a8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset result", 16'(res4), 16'h0000);
        chk("reset busy", 16'(busy4), 16'd0);
        chk("reset done", 16'(done4), 16'd0);
        @(negedge clk);
        rst = 1'b0;

        run(0, 3'd4, 8'hA, 16'h00A0, 0, 0, "concat_a0");
        run(0, 3'd0, 8'h9, 16'h0009, 0, 0, "add_09");
        run(0, 3'd7, 8'h3, 16'h0000, 0, 0, "clear");
        run(0, 3'd0, 8'h8, 16'h0008, 0, 0, "add_08");
        run(0, 3'd0, 8'hF, 16'h0017, 0, 0, "add_carry17");
        run(0, 3'd1, 8'h2, 16'h00FB, 0, 0, "sub_fb");
        run(0, 3'd2, 8'h6, 16'h002D, 0, 0, "logic_2d");
        run(0, 3'd3, 8'h0, 16'h000F, 0, 0, "any_one");
        run(0, 3'd7, 8'hF, 16'h0000, 0, 0, "clear2");
        run(0, 3'd3, 8'h0, 16'h0000, 0, 0, "any_zero");
        run(0, 3'd4, 8'h5, 16'h0050, 0, 0, "concat_50");
        run(0, 3'd5, 8'h3, 16'h0050, 0, 0, "hold");
        run(0, 3'd1, 8'h0, 16'h0000, 0, 0, "sub_zero");
        run(0, 3'd0, 8'hF, 16'h000F, 0, 0, "add_0f");
        run(0, 3'd0, 8'hF, 16'h001E, 0, 0, "add_max");
        run(0, 3'd1, 8'h0, 16'h00F2, 0, 0, "sub_wrap");

        // Back-to-back: second Start issued during the first Done cycle.
        @(negedge clk);
        st4 = 1'b1; op4 = 3'd4; a4 = 4'h3;
        exp_q.push_back(16'h0032);
        @(posedge clk); #1;
        op4 = 3'd0; a4 = 4'h4;
        exp_q.push_back(16'h0006);
        chk("b2b first done", 16'(done4), 16'd1);
        chk("b2b first result", 16'(res4), exp_q.pop_front());
        @(posedge clk); #1;
        st4 = 1'b0;
        chk("b2b second done", 16'(done4), 16'd1);
        chk("b2b second result", 16'(res4), exp_q.pop_front());
        chk("b2b busy", 16'(busy4), 16'd0);
        @(posedge clk); #1;
        chk("b2b done_low", 16'(done4), 16'd0);

`ifdef ALU_ACC_MUL_EN
        run(0, 3'd7, 8'h0, 16'h0000, 0, 0, "clear3");
        run(0, 3'd0, 8'h5, 16'h0005, 0, 0, "add_05");
        run(0, 3'd6, 8'h7, 16'h0023, 4, 1, "mul_5x7");
        // Reset two cycles into a multiply.
        @(negedge clk);
        st4 = 1'b1; op4 = 3'd6; a4 = 4'h2;
        @(posedge clk); #1;
        st4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mul_mid busy", 16'(busy4), 16'd1);
        chk("mul_mid result", 16'(res4), 16'h0023);
`else
        run(0, 3'd7, 8'h0, 16'h0000, 0, 0, "clear3");
        run(0, 3'd0, 8'h2, 16'h0002, 0, 0, "add_02");
        run(0, 3'd4, 8'h4, 16'h0042, 0, 0, "concat_42");
        run(0, 3'd6, 8'h7, 16'h0042, 0, 0, "op6_hold");
        @(posedge clk); #1;
        chk("op6 busy_idle", 16'(busy4), 16'd0);
`endif
        #2 rst = 1'b1;
        #1;
        chk("async rst result", 16'(res4), 16'h0000);
        chk("async rst busy", 16'(busy4), 16'd0);
        chk("async rst done", 16'(done4), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        run(0, 3'd4, 8'h3, 16'h0030, 0, 0, "post_rst_concat");

        run(1, 3'd0, 8'hFF, 16'h00FF, 0, 0, "w8 add_ff");
`ifdef ALU_ACC_MUL_EN
        run(1, 3'd6, 8'hFF, 16'hFE01, 8, 0, "w8 mul_ffxff");
`else
        run(1, 3'd0, 8'hFF, 16'h01FE, 0, 0, "w8 add_carry");
        run(1, 3'd6, 8'h12, 16'h01FE, 0, 0, "w8 op6_hold");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
